// File: rtl/pipe_control_pkg.sv
// pipe_control_pkg: opcodes, ALU-op codes and per-stage control bundle types
package pipe_control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam int ALU_W = 2;
   localparam logic [ALU_W-1:0] ALU_ADD   = 2'b00;
   localparam logic [ALU_W-1:0] ALU_SUB   = 2'b01;
   localparam logic [ALU_W-1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic             regdst;
      logic             alusrc;
      logic [ALU_W-1:0] aluop;
   } ex_ctrl_t;

   typedef struct packed {
      logic branch;
      logic memread;
      logic memwrite;
   } mem_ctrl_t;

   typedef struct packed {
      logic memtoreg;
      logic regwrite;
   } wb_ctrl_t;

   typedef struct packed {
      ex_ctrl_t  ex;
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
      logic      illegal;
   } id_bundle_t;

endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode to control-bundle decode
module control_decode
   import pipe_control_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter bit EN_JUMP  = 1'b1
) (
   input  logic [OPCODE_W-1:0] instru,
   input  logic                valid,
   output id_bundle_t          bundle,
   output logic                jump
);

   // decode a valid opcode; anything unlisted raises the illegal bit
   always_comb begin
      bundle = '0;
      jump   = 1'b0;
      if (valid) begin
         case (instru)
            OPCODE_W'(OP_RTYPE): begin
               bundle.ex.regdst   = 1'b1;
               bundle.ex.aluop    = ALU_FUNCT;
               bundle.wb.regwrite = 1'b1;
            end
            OPCODE_W'(OP_LW): begin
               bundle.ex.alusrc   = 1'b1;
               bundle.ex.aluop    = ALU_ADD;
               bundle.mem.memread = 1'b1;
               bundle.wb.memtoreg = 1'b1;
               bundle.wb.regwrite = 1'b1;
            end
            OPCODE_W'(OP_SW): begin
               bundle.ex.alusrc    = 1'b1;
               bundle.ex.aluop     = ALU_ADD;
               bundle.mem.memwrite = 1'b1;
            end
            OPCODE_W'(OP_BEQ): begin
               bundle.ex.aluop   = ALU_SUB;
               bundle.mem.branch = 1'b1;
            end
            OPCODE_W'(OP_ADDI): begin
               bundle.ex.alusrc   = 1'b1;
               bundle.ex.aluop    = ALU_ADD;
               bundle.wb.regwrite = 1'b1;
            end
            OPCODE_W'(OP_J): begin
               jump           = EN_JUMP;
               bundle.illegal = !EN_JUMP;
            end
            default: bundle.illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/pipe_control.sv
// pipe_control: pipelined control with load-use stall and branch flush
module pipe_control
   import pipe_control_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int REG_W    = 5,
   parameter int ALUOP_W  = 2,
   parameter bit EN_JUMP  = 1'b1
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [OPCODE_W-1:0] i_con_instru,
   input  logic                i_con_valid,
   input  logic [REG_W-1:0]    i_con_rs,
   input  logic [REG_W-1:0]    i_con_rt,
   input  logic                i_con_flush,
   output logic                o_con_stall,
   output logic                o_con_jump,
   output logic                o_con_regdst,
   output logic                o_con_alusrc,
   output logic [ALUOP_W-1:0]  o_con_aluop,
   output logic [REG_W-1:0]    o_con_ex_rt,
   output logic                o_con_illegal,
   output logic                o_con_branch,
   output logic                o_con_memread,
   output logic                o_con_memwrite,
   output logic                o_con_memtoreg,
   output logic                o_con_regwrite
);

   id_bundle_t       dec;
   logic             dec_jump;
   id_bundle_t       id_ex;
   logic [REG_W-1:0] ex_rt;
   mem_ctrl_t        ex_mem_m;
   wb_ctrl_t         ex_mem_w;
   wb_ctrl_t         mem_wb;

   control_decode #(.OPCODE_W(OPCODE_W), .EN_JUMP(EN_JUMP)) u_dec (
      .instru (i_con_instru),
      .valid  (i_con_valid),
      .bundle (dec),
      .jump   (dec_jump)
   );

   // load in EX whose rt feeds the ID instruction; r0 never creates a hazard
   always_comb begin
      o_con_stall = i_con_valid & id_ex.mem.memread & ((ex_rt == i_con_rs) | (ex_rt == i_con_rt)) & (ex_rt != '0);
      o_con_jump  = dec_jump & ~o_con_stall;
   end

   // ID/EX: bubble on flush or stall, otherwise take the fresh decode
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         id_ex <= '0;
         ex_rt <= '0;
      end else begin
         id_ex <= (i_con_flush | o_con_stall) ? '0 : dec;
         ex_rt <= (i_con_flush | o_con_stall) ? '0 : i_con_rt;
      end
   end

   // EX/MEM: squashed by a flush, unaffected by a stall
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ex_mem_m <= '0;
         ex_mem_w <= '0;
      end else begin
         ex_mem_m <= i_con_flush ? '0 : id_ex.mem;
         ex_mem_w <= i_con_flush ? '0 : id_ex.wb;
      end
   end

   // MEM/WB: always advances so the resolving branch commits
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) mem_wb <= '0;
      else          mem_wb <= ex_mem_w;
   end

   assign o_con_regdst   = id_ex.ex.regdst;
   assign o_con_alusrc   = id_ex.ex.alusrc;
   assign o_con_aluop    = ALUOP_W'(id_ex.ex.aluop);
   assign o_con_ex_rt    = ex_rt;
   assign o_con_illegal  = id_ex.illegal;
   assign o_con_branch   = ex_mem_m.branch;
   assign o_con_memread  = ex_mem_m.memread;
   assign o_con_memwrite = ex_mem_m.memwrite;
   assign o_con_memtoreg = mem_wb.memtoreg;
   assign o_con_regwrite = mem_wb.regwrite;

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: vector table, corner sequences and random run against a stage model
module tb_pipe_control;

   localparam logic [5:0] LW = 6'b100011, RT = 6'b000000, SW = 6'b101011;
   localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, IL = 6'b111111, AD = 6'b001000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op = '0;
   logic       valid = 1'b0;
   logic [4:0] rs = '0, rt = '0;
   logic       flush = 1'b0;

   logic       st1, jp1, rd1, as1, il1, br1, mr1, mw1, mt1, rw1;
   logic [1:0] ao1;
   logic [4:0] er1;
   logic       st0, jp0, rd0, as0, il0, br0, mr0, mw0, mt0, rw0;
   logic [1:0] ao0;
   logic [4:0] er0;
   logic [16:0] got [2];

   int vecs = 0, errs = 0;

   always #5 clk = ~clk;

   pipe_control #(.EN_JUMP(1'b1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_con_instru(op), .i_con_valid(valid),
      .i_con_rs(rs), .i_con_rt(rt), .i_con_flush(flush),
      .o_con_stall(st1), .o_con_jump(jp1), .o_con_regdst(rd1), .o_con_alusrc(as1),
      .o_con_aluop(ao1), .o_con_ex_rt(er1), .o_con_illegal(il1), .o_con_branch(br1),
      .o_con_memread(mr1), .o_con_memwrite(mw1), .o_con_memtoreg(mt1), .o_con_regwrite(rw1)
   );

   pipe_control #(.EN_JUMP(1'b0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_con_instru(op), .i_con_valid(valid),
      .i_con_rs(rs), .i_con_rt(rt), .i_con_flush(flush),
      .o_con_stall(st0), .o_con_jump(jp0), .o_con_regdst(rd0), .o_con_alusrc(as0),
      .o_con_aluop(ao0), .o_con_ex_rt(er0), .o_con_illegal(il0), .o_con_branch(br0),
      .o_con_memread(mr0), .o_con_memwrite(mw0), .o_con_memtoreg(mt0), .o_con_regwrite(rw0)
   );

   assign got[1] = {st1, jp1, rd1, as1, ao1, er1, il1, br1, mr1, mw1, mt1, rw1};
   assign got[0] = {st0, jp0, rd0, as0, ao0, er0, il0, br0, mr0, mw0, mt0, rw0};

   typedef struct packed {
      logic       regdst, alusrc;
      logic [1:0] aluop;
      logic       branch, memread, memwrite, memtoreg, regwrite, illegal;
      logic [4:0] rt;
   } m_t;

   // pm[e][k]: instruction k stages past ID (0 = EX, 1 = MEM, 2 = WB); e = EN_JUMP
   m_t pm [2][3];

   function automatic m_t mdec(logic [5:0] o, logic v, bit en);
      m_t m = '0;
      if (v) begin
         case (o)
            RT: begin m.regdst = 1; m.regwrite = 1; m.aluop = 2'b10; end
            LW: begin m.alusrc = 1; m.memread = 1; m.memtoreg = 1; m.regwrite = 1; end
            SW: begin m.alusrc = 1; m.memwrite = 1; end
            BQ: begin m.branch = 1; m.aluop = 2'b01; end
            AD: begin m.alusrc = 1; m.regwrite = 1; end
            JJ: m.illegal = !en;
            default: m.illegal = 1;
         endcase
      end
      return m;
   endfunction

   function automatic logic mstall(int e);
      return valid && pm[e][0].memread && (pm[e][0].rt == rs || pm[e][0].rt == rt) && pm[e][0].rt != 0;
   endfunction

   function automatic logic [16:0] mexp(int e);
      logic s = mstall(e);
      return {s, valid && op == JJ && e == 1 && !s, pm[e][0].regdst, pm[e][0].alusrc, pm[e][0].aluop,
              pm[e][0].rt, pm[e][0].illegal, pm[e][1].branch, pm[e][1].memread, pm[e][1].memwrite,
              pm[e][2].memtoreg, pm[e][2].regwrite};
   endfunction

   task automatic mreset();
      for (int e = 0; e < 2; e++) for (int k = 0; k < 3; k++) pm[e][k] = '0;
   endtask

   task automatic mupdate();
      for (int e = 0; e < 2; e++) begin
         logic s = mstall(e);
         m_t n = mdec(op, valid, e == 1);
         n.rt = rt;
         pm[e][2] = pm[e][1];
         pm[e][1] = flush ? '0 : pm[e][0];
         pm[e][0] = (flush || s) ? '0 : n;
      end
   endtask

   task automatic check(string nm, int e, logic [16:0] g, logic [16:0] w);
      vecs++;
      if (g !== w) begin
         errs++;
         $display("FAIL %s dut_en%0d got %b want %b", nm, e, g, w);
      end
   endtask

   typedef struct packed {
      logic [5:0] op;
      logic       v;
      logic [4:0] rs, rt;
      logic       fl, st, jp;
      logic [3:0] ex;
      logic [2:0] mem;
      logic [1:0] wb;
      logic       il, il0;
   } row_t;

   row_t tbl [31];

   task automatic step(string nm, int r);
      @(negedge clk);
      for (int e = 0; e < 2; e++) check(nm, e, got[e], mexp(e));
      if (r >= 0) begin
         vecs++;
         if ({st1, jp1, rd1, as1, ao1, br1, mr1, mw1, mt1, rw1, il1, il0} !==
             {tbl[r].st, tbl[r].jp, tbl[r].ex, tbl[r].mem, tbl[r].wb, tbl[r].il, tbl[r].il0}) begin
            errs++;
            $display("FAIL table row %0d got %b want %b", r,
                     {st1, jp1, rd1, as1, ao1, br1, mr1, mw1, mt1, rw1, il1, il0},
                     {tbl[r].st, tbl[r].jp, tbl[r].ex, tbl[r].mem, tbl[r].wb, tbl[r].il, tbl[r].il0});
         end
      end
      @(posedge clk);
      mupdate();
      #1;
   endtask

   task automatic drive(logic [5:0] o, logic v, logic [4:0] s, logic [4:0] t, logic f);
      op = o; valid = v; rs = s; rt = t; flush = f;
   endtask

   initial begin
      //        op  v  rs rt fl   st jp ex       mem     wb     il il0
      tbl[0]  = '{LW, 1, 1, 5, 0,  0, 0, 4'b0000, 3'b000, 2'b00, 0, 0};
      tbl[1]  = '{RT, 0, 0, 0, 0,  0, 0, 4'b0100, 3'b000, 2'b00, 0, 0};
      tbl[2]  = '{RT, 0, 0, 0, 0,  0, 0, 4'b0000, 3'b010, 2'b00, 0, 0};
      tbl[3]  = '{RT, 0, 0, 0, 0,  0, 0, 4'b0000, 3'b000, 2'b11, 0, 0};
      tbl[4]  = '{LW, 1, 1, 5, 0,  0, 0, 4'b0000, 3'b000, 2'b00, 0, 0};
      tbl[5]  = '{RT, 1, 5, 7, 0,  1, 0, 4'b0100, 3'b000, 2'b00, 0, 0};
      tbl[6]  = '{RT, 1, 5, 7, 0,  0, 0, 4'b0000, 3'b010, 2'b00, 0, 0};
      tbl[7]  = '{RT, 0, 0, 0, 0,  0, 0, 4'b1010, 3'b000, 2'b11, 0, 0};
      tbl[8]  = '{RT, 0, 0, 0, 0,  0, 0, 4'b0000, 3'b000, 2'b00, 0, 0};
      tbl[9]  = '{RT, 0, 0, 0, 0,  0, 0, 4'b0000, 3'b000, 2'b01, 0, 0};
      tbl[10] = '{LW, 1, 0, 0, 0,  0, 0, 4'b0000, 3'b000, 2'b00, 0, 0};
      tbl[11] = '{RT, 1, 0, 0, 0,  0, 0, 4'b0100, 3'b000, 2'b00, 0, 0};
      tbl[12] = '{RT, 0, 0, 0, 0,  0, 0, 4'b1010, 3'b010, 2'b00, 0, 0};
      tbl[13] = '{RT, 0, 0, 0, 0,  0, 0, 4'b0000, 3'b000, 2'b11, 0, 0};
      tbl[14] = '{RT, 0, 0, 0, 0,  0, 0, 4'b0000, 3'b000, 2'b01, 0, 0};
      tbl[15] = '{RT, 0, 0, 0, 0,  0, 0, 4'b0000, 3'b000, 2'b00, 0, 0};
      tbl[16] = '{BQ, 1, 1, 2, 0,  0, 0, 4'b0000, 3'b000, 2'b00, 0, 0};
      tbl[17] = '{SW, 1, 3, 4, 0,  0, 0, 4'b0001, 3'b000, 2'b00, 0, 0};
      tbl[18] = '{RT, 0, 0, 0, 1,  0, 0, 4'b0100, 3'b100, 2'b00, 0, 0};
      tbl[19] = '{RT, 0, 0, 0, 0,  0, 0, 4'b0000, 3'b000, 2'b00, 0, 0};
      tbl[20] = '{RT, 0, 0, 0, 0,  0, 0, 4'b0000, 3'b000, 2'b00, 0, 0};
      tbl[21] = '{LW, 1, 1, 3, 0,  0, 0, 4'b0000, 3'b000, 2'b00, 0, 0};
      tbl[22] = '{RT, 1, 3, 6, 1,  1, 0, 4'b0100, 3'b000, 2'b00, 0, 0};
      tbl[23] = '{RT, 1, 3, 6, 0,  0, 0, 4'b0000, 3'b000, 2'b00, 0, 0};
      tbl[24] = '{RT, 0, 0, 0, 0,  0, 0, 4'b1010, 3'b000, 2'b00, 0, 0};
      tbl[25] = '{RT, 0, 0, 0, 0,  0, 0, 4'b0000, 3'b000, 2'b00, 0, 0};
      tbl[26] = '{IL, 1, 0, 0, 0,  0, 0, 4'b0000, 3'b000, 2'b01, 0, 0};
      tbl[27] = '{RT, 0, 0, 0, 0,  0, 0, 4'b0000, 3'b000, 2'b00, 1, 1};
      tbl[28] = '{JJ, 1, 0, 0, 0,  0, 1, 4'b0000, 3'b000, 2'b00, 0, 0};
      tbl[29] = '{RT, 0, 0, 0, 0,  0, 0, 4'b0000, 3'b000, 2'b00, 0, 1};
      tbl[30] = '{RT, 0, 0, 0, 0,  0, 0, 4'b0000, 3'b000, 2'b00, 0, 0};

      mreset();
      #12;
      for (int e = 0; e < 2; e++) check("reset", e, got[e], mexp(e));
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      mupdate();
      #1;

      for (int r = 0; r < 31; r++) begin
         drive(tbl[r].op, tbl[r].v, tbl[r].rs, tbl[r].rt, tbl[r].fl);
         step("table_model", r);
      end

      drive(LW, 1, 1, 2, 0); step("inflight_lw", -1);
      drive(RT, 1, 3, 4, 0); step("inflight_r", -1);
      drive(SW, 1, 2, 6, 0); step("inflight_sw", -1);
      drive(LW, 1, 0, 6, 0);
      #2 rst_n = 1'b0;
      #1;
      mreset();
      for (int e = 0; e < 2; e++) check("async_reset", e, got[e], mexp(e));
      drive(AD, 1, 6, 9, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      mupdate();
      #1;
      drive(RT, 1, 9, 1, 0); step("after_reset", -1);
      drive(RT, 0, 0, 0, 0); step("after_reset2", -1);

      for (int i = 0; i < 400; i++) begin
         logic [5:0] ops [7];
         ops = '{RT, LW, SW, BQ, AD, JJ, 6'($urandom)};
         drive(ops[$urandom_range(0, 6)], $urandom_range(0, 3) != 0,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
         step("random", -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Parametrised pipelined successor to the single-cycle MIPS opcode decoder.
- Decodes the 6-bit opcode in ID into a control bundle and carries the EX/MEM/WB fields through ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and inserts a bubble on stall.
- Squashes in-flight control on a taken-branch flush.
- Adds addi and optional jump decode, plus an illegal-opcode flag.

Parameters:
- OPCODE_W, 6, opcode field width.
- REG_W, 5, register-address width for hazard compare.
- ALUOP_W, 2, ALU-op code width.
- EN_JUMP, 1, when 1, decode j (000010) and drive o_con_jump; when 0, j is treated as illegal.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_con_instru  in  OPCODE_W  ID-stage opcode.
- i_con_valid  in  1  ID holds a real instruction.
- i_con_rs  in  REG_W  ID source reg rs.
- i_con_rt  in  REG_W  ID source/dest reg rt.
- i_con_flush  in  1  branch taken, resolved in MEM.
- o_con_stall  out  1  load-use stall; hold PC and IF/ID (combinational).
- o_con_jump  out  1  ID-stage jump decode (combinational).
- o_con_regdst  out  1  EX stage.
- o_con_alusrc  out  1  EX stage.
- o_con_aluop  out  ALUOP_W  EX stage.
- o_con_ex_rt  out  REG_W  EX-stage rt (registered).
- o_con_illegal  out  1  EX-stage illegal-opcode flag.
- o_con_branch  out  1  MEM stage.
- o_con_memread  out  1  MEM stage.
- o_con_memwrite  out  1  MEM stage.
- o_con_memtoreg  out  1  WB stage.
- o_con_regwrite  out  1  WB stage.

Behaviour:
- Decode (combinational, ID stage; bundle fields {regdst, alusrc, aluop, branch, memread, memwrite, memtoreg, regwrite}):
  - R-type 000000: regdst=1, regwrite=1, aluop=10.
  - lw 100011: alusrc=1, memread=1, memtoreg=1, regwrite=1, aluop=00.
  - sw 101011: alusrc=1, memwrite=1, aluop=00.
  - beq 000100: branch=1, aluop=01.
  - addi 001000: alusrc=1, regwrite=1, aluop=00.
  - j 000010 with EN_JUMP=1: all bundle bits 0; o_con_jump=1 when i_con_valid.
  - Any other opcode, or i_con_valid=0: bundle all 0. The illegal bit is set only if valid=1 and the opcode is not listed.
  - The illegal bit travels with the bundle into EX as o_con_illegal.
- Hazard (combinational):
  - o_con_stall = i_con_valid & EX.memread & (EX.rt == i_con_rs | EX.rt == i_con_rt) & EX.rt != 0.
  - o_con_jump is suppressed (forced 0) while o_con_stall=1.
- Pipeline, per rising i_clk:
  - ID/EX stage takes the decoded bundle and i_con_rt.
  - EX/MEM stage takes the MEM+WB fields of ID/EX.
  - MEM/WB stage takes the WB fields of EX/MEM.
  - Latency: opcode to EX outputs is 1 cycle, to MEM outputs 2 cycles, to WB outputs 3 cycles.
- Stall:
  - ID/EX loads all zeros (bubble, including illegal and rt); EX/MEM and MEM/WB advance normally.
  - The upstream IF/ID holds, so the same opcode is re-decoded next cycle.
  - The stall clears after exactly one bubble for a single load-use pair.
- Flush:
  - ID/EX and EX/MEM load zeros; MEM/WB advances normally, so the branch's own WB fields (all 0) commit.
- Priority: flush > stall > normal. With flush and stall both asserted, flush behaviour applies.
- Reset (i_rst_n=0, asynchronous):
  - All stage registers clear to 0, so every registered output is 0.
  - Combinational outputs follow: o_con_stall=0 because EX.memread=0.
  - Reset mid-stream discards all in-flight bundles; the first edge after release loads the current decode.
- No back-pressure beyond stall; the block has no other state.

Decomposition:
- Package pipe_control_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - aluop constants (ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10);
  - packed structs ex_ctrl_t, mem_ctrl_t, wb_ctrl_t and id_bundle_t.
- Sub-module control_decode holds the combinational opcode-to-bundle decode, reusable by a future multicycle core.
- Stage registers and hazard logic stay in pipe_control.

Test Plan:
- Reset, then lw (100011) valid with rt=5, then idle: cycle 1 alusrc=1, aluop=00; cycle 2 memread=1; cycle 3 memtoreg=1, regwrite=1.
- lw rt=5, followed by R-type with rs=5: stall=1 in the 2nd cycle; next edge EX outputs all 0 (bubble); the following cycle R-type reaches EX with regdst=1, aluop=10, and stall=0.
- lw rt=0, followed by R-type with rs=0: stall stays 0.
- beq then sw, then i_con_flush=1 in beq's MEM cycle: next edge branch, memwrite, regdst, alusrc and aluop are all 0; no memwrite pulse ever appears for the sw.
- Opcode 111111 valid: o_con_illegal=1 one cycle later, all other outputs 0. Opcode 000010 with EN_JUMP=1: o_con_jump=1 combinationally; with EN_JUMP=0: o_con_illegal=1 next cycle.
- i_rst_n pulsed low mid-stream with 3 instructions in flight: all outputs 0 immediately (asynchronous); stall and flush asserted together give the flush result.
